// File: rtl/nn_infer_sched.sv
`default_nettype none
// ============================================================================
// Module   : nn_infer_sched
// Brief    : Credit-based inference scheduler in front of a fixed-latency
//            top_nn; tags frames, tracks them in flight, buffers results.
// Revision : 1.0 - initial release
// ============================================================================
module nn_infer_sched #(
    parameter int IN_SIZE    = 13,
    parameter int NN_LATENCY = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_vector       [IN_SIZE],
    output logic signed [15:0] nn_input_vector [IN_SIZE],
    input  logic        [1:0]  nn_output_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [1:0]  out_class,
    output logic        [7:0]  out_seq,
    output logic               busy
);

    localparam int c_STAGES = NN_LATENCY + 1;
    localparam int c_CNT_W  = $clog2(NN_LATENCY + 2);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_SUM_W  = ((c_CNT_W > c_FCNT_W) ? c_CNT_W : c_FCNT_W) + 1;
    localparam logic [c_FCNT_W-1:0] c_FULL = c_FCNT_W'(FIFO_DEPTH);

    logic signed [15:0]  r_vec_q [IN_SIZE];
    logic signed [15:0]  w_vec_d [IN_SIZE];
    logic [c_STAGES-1:0] r_vld_q, w_vld_d;
    logic [7:0]          r_tag_q [c_STAGES];
    logic [7:0]          w_tag_d [c_STAGES];
    logic [7:0]          r_seq_q, w_seq_d;
    logic [c_CNT_W-1:0]  r_inflight_q, w_inflight_d;
    logic [c_PTR_W-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [c_FCNT_W-1:0] r_count_q, w_count_d;
    logic [9:0]          r_mem_q [FIFO_DEPTH];
    logic [9:0]          w_mem_d [FIFO_DEPTH];

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [c_SUM_W-1:0]  w_credits_used;

    // Credits cover both frames in flight and results parked in the FIFO,
    // so every frame accepted is guaranteed a FIFO slot when it emerges.
    assign w_credits_used = c_SUM_W'(r_inflight_q) + c_SUM_W'(r_count_q);
    assign in_ready       = (w_credits_used < c_SUM_W'(FIFO_DEPTH));

    assign w_accept  = in_valid && in_ready;
    assign w_push    = r_vld_q[c_STAGES-1];
    assign out_valid = (r_count_q != '0);
    assign w_pop     = out_valid && out_ready;

    assign {out_class, out_seq} = r_mem_q[r_rd_ptr_q];
    assign busy                 = (r_inflight_q != '0) || (r_count_q != '0);
    assign nn_input_vector      = r_vec_q;

    always_comb begin
        w_vec_d      = r_vec_q;
        w_seq_d      = r_seq_q;
        w_vld_d      = {r_vld_q[c_STAGES-2:0], w_accept};
        w_tag_d[0]   = r_seq_q;
        for (int i = 1; i < c_STAGES; i++) begin
            w_tag_d[i] = r_tag_q[i-1];
        end
        w_inflight_d = r_inflight_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_mem_d      = r_mem_q;

        if (w_accept) begin
            w_vec_d = in_vector;
            w_seq_d = r_seq_q + 8'd1;
        end

        if (w_accept && !w_push) begin
            w_inflight_d = r_inflight_q + c_CNT_W'(1);
        end else if (!w_accept && w_push) begin
            w_inflight_d = r_inflight_q - c_CNT_W'(1);
        end

        // The last pipe stage lines up with the cycle top_nn's output is stable.
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = {nn_output_value, r_tag_q[c_STAGES-1]};
            w_wr_ptr_d          = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        if (w_push && !w_pop) begin
            w_count_d = r_count_q + c_FCNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count_q - c_FCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                r_vec_q[i] <= '0;
            end
            for (int i = 0; i < c_STAGES; i++) begin
                r_tag_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_vld_q      <= '0;
            r_seq_q      <= '0;
            r_inflight_q <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
        end else begin
            r_vec_q      <= w_vec_d;
            r_tag_q      <= w_tag_d;
            r_mem_q      <= w_mem_d;
            r_vld_q      <= w_vld_d;
            r_seq_q      <= w_seq_d;
            r_inflight_q <= w_inflight_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count_q == c_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_nn_infer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_infer_sched
// Brief    : Directed bench for nn_infer_sched with a fake fixed-latency
//            top_nn and an outstanding-frame queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_infer_sched;

    localparam int IN_SIZE    = 13;
    localparam int NN_LATENCY = 4;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_vector       [IN_SIZE];
    logic signed [15:0] nn_input_vector [IN_SIZE];
    logic        [1:0]  nn_output_value;
    logic               out_valid;
    logic               out_ready;
    logic        [1:0]  out_class;
    logic        [7:0]  out_seq;
    logic               busy;

    always #5 clk = ~clk;

    nn_infer_sched #(
        .IN_SIZE    (IN_SIZE),
        .NN_LATENCY (NN_LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_vector       (in_vector),
        .nn_input_vector (nn_input_vector),
        .nn_output_value (nn_output_value),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_class       (out_class),
        .out_seq         (out_seq),
        .busy            (busy)
    );

    // Fake top_nn: class = low 2 bits of feature 0, NN_LATENCY edges after
    // the input register updates; random junk when no frame is due.
    logic [1:0] d_cls  [1:NN_LATENCY];
    logic       a_flag [0:NN_LATENCY];
    logic [1:0] junk;

    always @(posedge clk) begin
        a_flag[0] <= in_valid && in_ready;
        for (int i = 1; i <= NN_LATENCY; i++) a_flag[i] <= a_flag[i-1];
        d_cls[1] <= nn_input_vector[0][1:0];
        for (int i = 2; i <= NN_LATENCY; i++) d_cls[i] <= d_cls[i-1];
        junk <= 2'($urandom);
    end

    assign nn_output_value = (a_flag[NN_LATENCY] === 1'b1) ? d_cls[NN_LATENCY] : junk;

    typedef struct {
        logic [1:0] cls;
        logic [7:0] seq;
        int         acc_edge;
    } exp_t;

    exp_t               q[$];
    int                 n_cmp = 0;
    int                 n_fail = 0;
    int                 n_out = 0;
    int                 edge_no = 0;
    bit                 started = 1'b0;
    logic [7:0]         mseq;
    logic signed [15:0] mvec [IN_SIZE];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every frame accepted and not yet popped is outstanding;
    // its result is visible once NN_LATENCY+1 edges have passed since accept.
    initial begin : compare_proc
        bit   exp_ov;
        bit   exp_rdy;
        bit   vok;
        exp_t e;
        forever begin
            @(negedge clk);
            exp_ov  = (q.size() != 0) && (edge_no >= q[0].acc_edge + NN_LATENCY + 1);
            exp_rdy = (q.size() < FIFO_DEPTH);
            if (started) begin
                chk("in_ready", in_ready, exp_rdy);
                chk("busy", busy, q.size() != 0);
                chk("out_valid", out_valid, exp_ov);
                if (exp_ov) begin
                    chk("out_class", out_class, q[0].cls);
                    chk("out_seq", out_seq, q[0].seq);
                end
                vok = 1'b1;
                for (int i = 0; i < IN_SIZE; i++) if (nn_input_vector[i] !== mvec[i]) vok = 1'b0;
                chk("nn_input_vector", vok, 1);
            end
            if (!rst && out_valid === 1'b1 && out_ready === 1'b1) n_out++;
            if (rst) begin
                q.delete();
                mseq = 8'd0;
                for (int i = 0; i < IN_SIZE; i++) mvec[i] = '0;
                started = 1'b1;
            end else if (started) begin
                if (exp_ov && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy) begin
                    e.cls      = in_vector[0][1:0];
                    e.seq      = mseq;
                    e.acc_edge = edge_no + 1;
                    q.push_back(e);
                    mseq = mseq + 8'd1;
                    mvec = in_vector;
                end
            end
            edge_no++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [15:0] v);
        for (int i = 0; i < IN_SIZE; i++) in_vector[i] = (i == 0) ? v : 16'(v ^ 16'(i * 257));
    endtask

    task automatic offer(input logic [15:0] v, input bit rnd);
        int k = 0;
        set_vec(v);
        in_valid = 1'b1;
        if (rnd) out_ready = 1'($urandom);
        while (in_ready !== 1'b1 && k < 64) begin
            tick();
            if (rnd) out_ready = 1'($urandom);
            k++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", in_ready, k);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, required finish before time limit");
        $fatal(1);
    end

    initial begin : driver
        int first_stall;
        int acc;
        int base;
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_vec(16'd0);
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_seq", out_seq, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);

        // Single frame: result visible exactly after accept edge + 5.
        offer(16'd2, 1'b0);
        repeat (4) tick();
        chk("t1_valid_early", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_class", out_class, 2);
        chk("t1_seq", out_seq, 0);
        tick();
        chk("t1_popped", out_valid, 0);
        chk("t1_busy", busy, 0);

        // Eight back-to-back frames, credit stall after four.
        first_stall = -1;
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            if (in_ready !== 1'b1 && first_stall < 0) first_stall = i;
            offer(16'(i + 1), 1'b0);
        end
        wait_idle("t2_drain", 40);
        chk("t2_first_stall", first_stall, 4);
        chk("t2_outputs", n_out - base, 8);

        // Consumer blocked: exactly FIFO_DEPTH frames get in.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 15; c++) begin
            set_vec(16'(21 + acc));
            in_valid = 1'b1;
            if (in_ready === 1'b1) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("t3_accepted", acc, 4);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_head_valid", out_valid, 1);
        chk("t3_head_seq", out_seq, 0);
        chk("t3_head_class", out_class, 1);
        out_ready = 1'b1;
        offer(16'd25, 1'b0);
        offer(16'd26, 1'b0);
        wait_idle("t3_drain", 40);

        // Idle gaps with junk on nn_output_value; input register must hold.
        for (int i = 0; i < 4; i++) begin
            offer(16'(40 + i), 1'b0);
            repeat (3) tick();
            chk("t4_hold_vec", $unsigned(nn_input_vector[0]), 40 + i);
        end
        wait_idle("t4_drain", 40);

        // 300 frames with a random consumer; tags wrap past 255.
        base = n_out;
        for (int i = 0; i < 300; i++) offer(16'($urandom), 1'b1);
        out_ready = 1'b1;
        wait_idle("t5_drain", 60);
        chk("t5_outputs", n_out - base, 300);

        // Reset with two in flight and two buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) offer(16'(60 + i), 1'b0);
        repeat (3) tick();
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 1);
        out_ready = 1'b1;
        offer(16'd3, 1'b0);
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            #4;
            @(posedge clk);
            #1;
            k++;
        end
        chk("t6_result_valid", out_valid, 1);
        chk("t6_seq", out_seq, 0);
        chk("t6_class", out_class, 3);
        wait_idle("t6_drain", 40);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nn_infer_sched.md
Name: nn_infer_sched

Overview:
- Inference scheduler in front of top_nn.
- Accepts feature vectors on a valid/ready handshake and drives top_nn's input_vector register.
- top_nn is fixed-latency and cannot stall, so the block tracks in-flight frames with a tagged shift pipe, captures each class result into an output FIFO, and issues credits so the FIFO can never overflow.
- Each result carries an 8-bit sequence tag.

Parameters:
- IN_SIZE, 13, number of 16-bit signed features per frame; equals IN_SIZE_1 of nn_parameters.
- NN_LATENCY, 4, edges from nn_input_vector update to a stable top_nn output_value.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  frame offered
- in_ready  output  1  credit available; frame accepted on in_valid && in_ready at posedge
- in_vector  input  16 signed x IN_SIZE (unpacked)  feature frame
- nn_input_vector  output  16 signed x IN_SIZE (unpacked)  to top_nn input_vector
- nn_output_value  input  2  from top_nn output_value
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head on out_valid && out_ready
- out_class  output  2  head class index
- out_seq  output  8  head sequence tag
- busy  output  1  any frame in flight or buffered

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - nn_input_vector all 0.
  - Valid pipe and tags cleared.
  - FIFO empty: rd/wr pointers 0, count 0.
  - inflight_cnt 0, seq counter 0.
  - out_valid 0, out_class 0, out_seq 0, in_ready 1 (derived), busy 0.
- Reset mid-operation: all in-flight and buffered results are discarded with no output. The first frame after reset gets seq 0.
- Credit rule:
  - in_ready = (inflight_cnt + fifo_count) < FIFO_DEPTH, computed from registered values only.
  - in_ready has no combinational dependence on in_valid or out_ready.
  - A same-cycle pop does not free a credit until the next cycle.
- Accept at edge E0:
  - nn_input_vector <= in_vector.
  - Pipe stage 0 <= {1, seq}.
  - seq <= seq+1, wrapping 255->0.
  - inflight_cnt increments.
- No accept: nn_input_vector holds its value (no toggling). Stage 0 <= {0, x}.
- Pipe:
  - NN_LATENCY+1 stages of {vld, tag[7:0]}, shifted every cycle unconditionally.
  - The last stage is high during the cycle between E0+NN_LATENCY and E0+NN_LATENCY+1, when top_nn's output for that frame is stable.
  - At edge E0+NN_LATENCY+1 with last-stage vld: push {nn_output_value, tag} into the FIFO and decrement inflight_cnt.
  - Results of non-accepted cycles are never pushed.
- Latency: out_valid rises in the cycle after edge E0+NN_LATENCY+1 (default: 5 edges after accept) if the FIFO was empty.
- Throughput: one frame per cycle while credits last. Back-to-back accepts produce back-to-back pushes.
- FIFO:
  - Registered head: out_class and out_seq come from rd pointer storage.
  - out_valid = count != 0.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop on empty is ignored; out_ready is don't-care while out_valid=0.
  - Overflow is impossible by the credit rule; an SVA assertion flags push with count==FIFO_DEPTH.
- Output stability: out_valid, out_class, out_seq are held stable while out_valid && !out_ready.
- Counters: inflight_cnt width clog2(NN_LATENCY+2). Simultaneous accept and push leaves inflight_cnt unchanged.
- busy = inflight_cnt != 0 || fifo_count != 0.
- Ordering: results leave strictly in acceptance order, and tags are consecutive modulo 256.

Test Plan:
- Reset then a single frame at E0, model class 2, out_ready=1 -> out_valid first high after E5 with out_class=2, out_seq=0; popped at the next edge; busy back to 0 the cycle after.
- 8 back-to-back frames, out_ready=1, FIFO_DEPTH=4 -> in_ready drops after 4 accepts; stall lasts until pushes/pops free credits; all 8 outputs have seq 0..7 in order with no loss.
- out_ready=0, 6 frames offered -> exactly 4 accepted, in_ready=0 thereafter, FIFO count 4, head seq 0 stable; release out_ready -> seq 0..3 drain, then frames 4..5 accepted.
- Idle cycles between frames with the model output toggling -> no spurious pushes; nn_input_vector holds the last accepted frame.
- 300 frames with random out_ready -> seq wraps 255->0; order and class match a reference queue; overflow assertion never fires.
- Assert rst with 2 in flight and 2 buffered -> next cycle out_valid=0, busy=0, in_ready=1; the next accepted frame's result has out_seq=0 and no stale results appear.
